// File: rtl/piso_tx_if.sv
// piso_tx_if: parallel word handshake in, serial bit stream out.
interface piso_tx_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] i_data;
  logic i_valid;
  logic o_ready;
  logic o_d;
  logic o_d_valid;
  logic o_last;
  logic o_busy;
  modport master(output i_data, i_valid, input o_ready, o_d, o_d_valid, o_last, o_busy);
  modport slave(input i_data, i_valid, output o_ready, o_d, o_d_valid, o_last, o_busy);
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with one-word holding register.
// Words queue into the holding register while shifting, so streams stay gap-free.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input logic i_clk,
  input logic i_rst_n,
  piso_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sh, sh_n, hold, hold_n, adv;
  logic [CW-1:0] cnt, cnt_n;
  logic full, full_n, accept, last, head;
  // ready is forced low combinationally while reset is held
  assign bus.o_ready  = i_rst_n & ~full;
  assign accept       = bus.i_valid & bus.o_ready;
  assign last         = (state == SHIFT) && (cnt == LAST);
  assign head         = MSB_FIRST ? sh[WIDTH-1] : sh[0];
  assign adv          = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
  assign bus.o_d       = (state == SHIFT) & head;
  assign bus.o_d_valid = (state == SHIFT);
  assign bus.o_last    = last;
  assign bus.o_busy    = (state == SHIFT) | full;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      hold  <= '0;
      full  <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      hold  <= hold_n;
      full  <= full_n;
    end
  end
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    hold_n  = hold;
    full_n  = full;
    if (state == IDLE) begin
      if (accept) begin
        sh_n    = bus.i_data;
        cnt_n   = '0;
        state_n = SHIFT;
      end
    end else if (!last) begin
      sh_n  = adv;
      cnt_n = cnt + 1'b1;
      if (accept) begin
        hold_n = bus.i_data;
        full_n = 1'b1;
      end
    end else if (full) begin
      sh_n   = hold;
      full_n = 1'b0;
      cnt_n  = '0;
    end else if (accept) begin
      sh_n  = bus.i_data;
      cnt_n = '0;
    end else begin
      sh_n    = '0;
      cnt_n   = '0;
      state_n = IDLE;
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx, one MSB-first and one LSB-first instance.
module tb_piso_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic pv0 = 1'b0;
  logic pv1 = 1'b0;
  int w;
  logic l;
  piso_tx_if #(.WIDTH(8)) b0();
  piso_tx_if #(.WIDTH(8)) b1();
  piso_tx #(.WIDTH(8), .MSB_FIRST(1)) u0(.i_clk(clk), .i_rst_n(rst_n), .bus(b0.slave));
  piso_tx #(.WIDTH(8), .MSB_FIRST(0)) u1(.i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // scoreboard pops: each valid output cycle consumes one {bit,last} entry
  always @(negedge clk) begin
    logic [1:0] e;
    if (b0.o_d_valid) begin
      if (q0.size() == 0) check("spare0", b0.o_d_valid, 0);
      else begin
        e = q0.pop_front();
        check("bit0", b0.o_d, e[1]);
        check("last0", b0.o_last, e[0]);
      end
    end else if (pv0) check("gap0", q0.size(), 0);
    pv0 = b0.o_d_valid;
  end
  always @(negedge clk) begin
    logic [1:0] e;
    if (b1.o_d_valid) begin
      if (q1.size() == 0) check("spare1", b1.o_d_valid, 0);
      else begin
        e = q1.pop_front();
        check("bit1", b1.o_d, e[1]);
        check("last1", b1.o_last, e[0]);
      end
    end else if (pv1) check("gap1", q1.size(), 0);
    pv1 = b1.o_d_valid;
  end
  task automatic send(input int sel, input logic [7:0] d, output int waits, output logic lst);
    bit ok = 0;
    waits = 0;
    lst = 0;
    while (!ok && waits < 40) begin
      @(negedge clk);
      if (sel != 0) begin b1.i_data = d; b1.i_valid = 1'b1; end
      else begin b0.i_data = d; b0.i_valid = 1'b1; end
      if ((sel != 0) ? b1.o_ready : b0.o_ready) begin
        ok = 1;
        lst = (sel != 0) ? b1.o_last : b0.o_last;
        for (int i = 0; i < 8; i++)
          if (sel != 0) q1.push_back({d[i], i == 7});
          else q0.push_back({d[7-i], i == 7});
      end else waits++;
    end
    check("send_ok", ok, 1);
    @(posedge clk);
    #1;
    b0.i_valid = 1'b0;
    b1.i_valid = 1'b0;
  endtask
  task automatic drain(input int sel);
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (sel != 0 && q1.size() == 0 && !b1.o_d_valid && !b1.o_busy) break;
      if (sel == 0 && q0.size() == 0 && !b0.o_d_valid && !b0.o_busy) break;
    end
    check("drained", (sel != 0) ? q1.size() : q0.size(), 0);
    check("idle_valid", (sel != 0) ? b1.o_d_valid : b0.o_d_valid, 0);
    check("idle_d", (sel != 0) ? b1.o_d : b0.o_d, 0);
    check("idle_last", (sel != 0) ? b1.o_last : b0.o_last, 0);
    check("idle_busy", (sel != 0) ? b1.o_busy : b0.o_busy, 0);
  endtask
  initial begin
    b0.i_valid = 1'b0; b0.i_data = '0;
    b1.i_valid = 1'b0; b1.i_data = '0;
    #1;
    check("rst_ready", b0.o_ready, 0);
    check("rst_valid", b0.o_d_valid, 0);
    check("rst_busy", b0.o_busy, 0);
    check("rst_d", b0.o_d, 0);
    check("rst_last", b0.o_last, 0);
    #21 rst_n = 1'b1;
    #1 check("rel_ready", b0.o_ready, 1);
    send(0, 8'hA5, w, l);
    check("a5_wait", w, 0);
    drain(0);
    send(1, 8'h01, w, l);
    drain(1);
    send(0, 8'hA5, w, l);
    send(0, 8'h3C, w, l);
    drain(0);
    send(0, 8'h11, w, l);
    send(0, 8'h22, w, l);
    check("bp_ready", b0.o_ready, 0);
    check("bp_busy", b0.o_busy, 1);
    send(0, 8'h33, w, l);
    check("bp_wait", w, 7);
    drain(0);
    send(0, 8'hA5, w, l);
    repeat (7) @(negedge clk);
    send(0, 8'h5A, w, l);
    check("byp_wait", w, 0);
    check("byp_on_last", l, 1);
    check("byp_ready", b0.o_ready, 1);
    drain(0);
    send(0, 8'hFF, w, l);
    send(0, 8'h0F, w, l);
    repeat (2) @(posedge clk);
    check("pre_rst_busy", b0.o_busy, 1);
    #2 rst_n = 1'b0;
    q0.delete();
    #1;
    check("arst_d", b0.o_d, 0);
    check("arst_valid", b0.o_d_valid, 0);
    check("arst_last", b0.o_last, 0);
    check("arst_busy", b0.o_busy, 0);
    check("arst_ready", b0.o_ready, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("rel2_ready", b0.o_ready, 1);
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", b0.o_d_valid, 0);
    end
    send(0, 8'h96, w, l);
    check("post_rst_wait", w, 0);
    drain(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
